// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM states and the divide-by-zero quotient value.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_ex_adder.sv
// Plain W-bit adder with carry in/out; used for both the shift-add multiply
// step and the restoring-divide trial subtraction.
module mdu_ex_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mdu_ex.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; fixed ITER+1 cycle latency,
// one shared adder, sign handled by magnitude operands plus a final fixup.
module mdu_ex
  import mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_mdu_i,
  input  logic [2:0]      op_mdu_i,
  input  logic [XLEN-1:0] opr_a_mdu_i,
  input  logic [XLEN-1:0] opr_b_mdu_i,
  input  logic            flush_mdu_i,
  output logic [XLEN-1:0] hi_mdu_o,
  output logic [XLEN-1:0] lo_mdu_o,
  output logic            busy_mdu_o,
  output logic            done_mdu_o
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  mdu_state_e      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi_q, lo_q;
  // acc_q: product high half / partial remainder; mq_q: multiplier / dividend->quotient
  logic [XLEN-1:0] acc_q, mq_q, opb_q;
  logic            sign_a_q, sign_b_q, is_div_q, div0_q, busy_q, done_q;

  // operand magnitudes for signed ops
  logic            is_signed, neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;

  assign is_signed = ~op_mdu_i[0];
  assign neg_a     = is_signed & opr_a_mdu_i[XLEN-1];
  assign neg_b     = is_signed & opr_b_mdu_i[XLEN-1];
  assign abs_a     = neg_a ? -opr_a_mdu_i : opr_a_mdu_i;
  assign abs_b     = neg_b ? -opr_b_mdu_i : opr_b_mdu_i;

  // step datapath
  logic [XLEN-1:0] add_a, add_b, add_sum, shl_rem;
  logic            add_cin, add_cout, div_ge;

  assign shl_rem = {acc_q[XLEN-2:0], mq_q[XLEN-1]};

  always_comb begin
    if (is_div_q) begin
      add_a   = shl_rem;
      add_b   = ~opb_q;
      add_cin = 1'b1;
    end else begin
      add_a   = acc_q;
      add_b   = mq_q[0] ? opb_q : '0;
      add_cin = 1'b0;
    end
  end

  mdu_ex_adder #(.W(XLEN)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The shifted remainder is XLEN+1 bits; a bit shifted out of the top means
  // it already exceeds any divisor, so the trial subtraction must succeed.
  assign div_ge = acc_q[XLEN-1] | add_cout;

  // final sign fixup
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fix_hi, fix_lo;

  assign prod = {acc_q, mq_q};

  always_comb begin
    fix_hi = acc_q;
    fix_lo = mq_q;
    if (is_div_q) begin
      // with a zero divisor every trial succeeds and the remainder ends as |a|,
      // so the dividend-signed remainder reproduces opr_a
      fix_hi = sign_a_q ? -acc_q : acc_q;
      if (div0_q)                  fix_lo = XLEN'(DIV0_LO);
      else if (sign_a_q ^ sign_b_q) fix_lo = -mq_q;
    end else if (sign_a_q ^ sign_b_q) begin
      {fix_hi, fix_lo} = -prod;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opb_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_mdu_i) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_mdu_i) begin
              if (!op_mdu_i[2]) begin
                is_div_q <= op_mdu_i[1];
                sign_a_q <= neg_a;
                sign_b_q <= neg_b;
                div0_q   <= (opr_b_mdu_i == '0);
                acc_q    <= '0;
                mq_q     <= op_mdu_i[1] ? abs_a : abs_b;
                opb_q    <= op_mdu_i[1] ? abs_b : abs_a;
                cnt      <= CW'(ITER - 1);
                busy_q   <= 1'b1;
                state    <= CALC;
              end else if (op_mdu_i == MDU_MTHI) begin
                hi_q <= opr_a_mdu_i;
              end else if (op_mdu_i == MDU_MTLO) begin
                lo_q <= opr_a_mdu_i;
              end
            end
          end
          CALC: begin
            if (is_div_q) begin
              acc_q <= div_ge ? add_sum : shl_rem;
              mq_q  <= {mq_q[XLEN-2:0], div_ge};
            end else begin
              acc_q <= {add_cout, add_sum[XLEN-1:1]};
              mq_q  <= {add_sum[0], mq_q[XLEN-1:1]};
            end
            if (cnt == '0) state <= FIXUP;
            else           cnt   <= cnt - 1'b1;
          end
          FIXUP: begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign hi_mdu_o   = hi_q;
  assign lo_mdu_o   = lo_q;
  assign busy_mdu_o = busy_q;
  assign done_mdu_o = done_q;

endmodule

// File: tb/tb_mdu_ex.sv
// Directed bench for mdu_ex: vector table for mult/div results and latency,
// hand sequences for MTHI/MTLO, flush, reset and start-while-busy.
module tb_mdu_ex;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        flush;
  logic [31:0] hi, lo;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_ex #(.XLEN(32), .ITER(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_mdu_i (start),
    .op_mdu_i    (op),
    .opr_a_mdu_i (opa),
    .opr_b_mdu_i (opb),
    .flush_mdu_i (flush),
    .hi_mdu_o    (hi),
    .lo_mdu_o    (lo),
    .busy_mdu_o  (busy),
    .done_mdu_o  (done)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and follow it to completion. If inj >= 0, a conflicting
  // MULTU is presented on start while busy at that busy cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int inj, output int busy_cyc, output int done_cnt);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0;
    done_cnt = 0;
    while (busy && busy_cyc < 100) begin
      busy_cyc++;
      if (done) done_cnt++;
      if (busy_cyc == inj) begin
        start = 1'b1; op = 3'b001; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (done) done_cnt++;
    @(negedge clk);
    if (done) done_cnt++;
  endtask

  // Start MULT 3x4 and assert flush at busy cycle n (33 lands on FIXUP).
  task automatic flush_run(input int n, input logic [31:0] hold_hi, input logic [31:0] hold_lo);
    int seen_done, seen_busy;
    @(negedge clk);
    start = 1'b1; op = 3'b000; opa = 32'd3; opb = 32'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < n; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check($sformatf("flush%0d_busy", n), {31'd0, busy}, 32'd0);
    seen_done = 0;
    seen_busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done++;
      if (busy) seen_busy++;
      @(negedge clk);
    end
    check($sformatf("flush%0d_done", n), seen_done, 0);
    check($sformatf("flush%0d_busy_later", n), seen_busy, 0);
    check($sformatf("flush%0d_hi", n), hi, hold_hi);
    check($sformatf("flush%0d_lo", n), lo, hold_lo);
  endtask

  initial begin
    int bc, dc, seen;

    vecs[0] = '{"multu_max",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{"mult_m3x7",   3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{"div_m7d2",    3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_100d7",  3'b011, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{"divu_5d0",    3'b011, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[5] = '{"div_min_m1",  3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[6] = '{"mult_m2xm3",  3'b000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0,         32'd6};
    vecs[7] = '{"div_m5d0",    3'b010, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[8] = '{"div_20dm6",   3'b010, 32'd20,        32'hFFFF_FFFA, 32'd2,         32'hFFFF_FFFD};

    reset = 1'b1; start = 1'b0; op = 3'b000; opa = '0; opb = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, bc, dc);
      check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
      check({vecs[i].name, "_busycyc"}, bc, 33);
      check({vecs[i].name, "_done"}, dc, 1);
    end

    // MTHI then MTLO back to back
    @(negedge clk);
    start = 1'b1; op = 3'b100; opa = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    op = 3'b101; opa = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi", hi, 32'h1234_5678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_done", {31'd0, done}, 32'd0);

    // undefined op is a no-op
    start = 1'b1; op = 3'b111; opa = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    check("undef_busy", {31'd0, busy}, 32'd0);
    check("undef_hi", hi, 32'h1234_5678);
    check("undef_lo", lo, 32'h9ABC_DEF0);

    flush_run(10, 32'h1234_5678, 32'h9ABC_DEF0);
    flush_run(33, 32'h1234_5678, 32'h9ABC_DEF0);

    // flush beats a same-cycle MTHI
    start = 1'b1; op = 3'b100; opa = 32'h5555_AAAA; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_mthi_hi", hi, 32'h1234_5678);

    // start while busy is ignored
    do_op(3'b011, 32'd1000, 32'd3, 10, bc, dc);
    check("busy_start_hi", hi, 32'd1);
    check("busy_start_lo", lo, 32'd333);
    check("busy_start_cyc", bc, 33);
    check("busy_start_done", dc, 1);

    // reset mid-divide
    @(negedge clk);
    start = 1'b1; op = 3'b011; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check("midrst_quiet", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
